// File: rtl/window_pkg.sv
// Shared pixel and window-column types for the 3x3 RGB444 window generator.
// Columns are indexed top (oldest line) to bottom (newest line).
package window_pkg;

  localparam int PIX_W = 12;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef pixel_t col_t [0:2];

  // The window becomes meaningful once two earlier columns/lines exist.
  localparam int WIN_LAG = 2;

endpackage

// File: rtl/window_3x3_gen_line_buffer.sv
// One-line pixel store: synchronous write, asynchronous read, no reset.
// Contents are never cleared; the window valid gate masks stale data.
module line_buffer
  import window_pkg::*;
#(
  parameter  int DEPTH = 320,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  pixel_t        i_wdata,
  input  logic [AW-1:0] i_raddr,
  output pixel_t        o_rdata
);

  pixel_t r_mem [0:DEPTH-1];

  // Read is combinational, so a same-address write this cycle returns the old word.
  assign o_rdata = r_mem[i_raddr];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

endmodule

// File: rtl/window_3x3_gen.sv
// Raster stream to registered 3x3 window taps using two line buffers.
// Optional macro WIN_COORD_EN adds the o_cx/o_cy window-center outputs.
module window_3x3_gen
  import window_pkg::*;
#(
  parameter  int IMG_WIDTH  = 320,
  parameter  int IMG_HEIGHT = 240,
  localparam int XW         = $clog2(IMG_WIDTH),
  localparam int YW         = $clog2(IMG_HEIGHT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_valid,
  input  logic          i_sof,
  input  pixel_t        i_pixel,
  output logic          o_valid,
  output pixel_t        PixelData_00,
  output pixel_t        PixelData_01,
  output pixel_t        PixelData_02,
  output pixel_t        PixelData_10,
  output pixel_t        PixelData_11,
  output pixel_t        PixelData_12,
  output pixel_t        PixelData_20,
  output pixel_t        PixelData_21,
  output pixel_t        PixelData_22
`ifdef WIN_COORD_EN
  ,
  output logic [XW-1:0] o_cx,
  output logic [YW-1:0] o_cy
`endif
);

  logic [XW-1:0] r_xCnt;
  logic [YW-1:0] r_yCnt;
  logic [XW-1:0] w_px;
  logic [YW-1:0] w_py;
  logic [XW-1:0] w_xNext;
  logic [YW-1:0] w_yNext;
  logic          w_winOk;
  pixel_t        w_lb1Rd;
  pixel_t        w_lb2Rd;
  col_t          r_win [0:2];
  logic          r_valid;

  // Position of the pixel being accepted: sof overrides the running count.
  always_comb begin
    w_px    = i_sof ? '0 : r_xCnt;
    w_py    = i_sof ? '0 : r_yCnt;
    w_xNext = w_px + 1'b1;
    w_yNext = w_py;
    if (w_px == XW'(IMG_WIDTH - 1)) begin
      w_xNext = '0;
      w_yNext = (w_py == YW'(IMG_HEIGHT - 1)) ? '0 : w_py + 1'b1;
    end
    w_winOk = (w_px >= XW'(WIN_LAG)) && (w_py >= YW'(WIN_LAG));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_xCnt <= '0;
      r_yCnt <= '0;
    end else if (i_valid) begin
      r_xCnt <= w_xNext;
      r_yCnt <= w_yNext;
    end
  end

  line_buffer #(.DEPTH(IMG_WIDTH)) lb1 (
    .clk     (clk),
    .i_we    (i_valid),
    .i_waddr (w_px),
    .i_wdata (i_pixel),
    .i_raddr (w_px),
    .o_rdata (w_lb1Rd)
  );

  line_buffer #(.DEPTH(IMG_WIDTH)) lb2 (
    .clk     (clk),
    .i_we    (i_valid),
    .i_waddr (w_px),
    .i_wdata (w_lb1Rd),
    .i_raddr (w_px),
    .o_rdata (w_lb2Rd)
  );

  // Column 2 is the newest column; each accepted pixel pushes the window left.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 3; c++) begin
        for (int r = 0; r < 3; r++) begin
          r_win[c][r] <= '0;
        end
      end
    end else if (i_valid) begin
      r_win[0]    <= r_win[1];
      r_win[1]    <= r_win[2];
      r_win[2][0] <= w_lb2Rd;
      r_win[2][1] <= w_lb1Rd;
      r_win[2][2] <= i_pixel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_valid && w_winOk;
    end
  end

`ifdef WIN_COORD_EN
  logic [XW-1:0] r_cx;
  logic [YW-1:0] r_cy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cx <= '0;
      r_cy <= '0;
    end else if (i_valid && w_winOk) begin
      r_cx <= w_px - 1'b1;
      r_cy <= w_py - 1'b1;
    end
  end

  assign o_cx = r_cx;
  assign o_cy = r_cy;
`endif

  assign o_valid      = r_valid;
  assign PixelData_00 = r_win[0][0];
  assign PixelData_01 = r_win[1][0];
  assign PixelData_02 = r_win[2][0];
  assign PixelData_10 = r_win[0][1];
  assign PixelData_11 = r_win[1][1];
  assign PixelData_12 = r_win[2][1];
  assign PixelData_20 = r_win[0][2];
  assign PixelData_21 = r_win[1][2];
  assign PixelData_22 = r_win[2][2];

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen on a 4x3 image; pixel value = {tag, y, x}.
// Coordinate checks are compiled in when WIN_COORD_EN is defined.
module tb_window_3x3_gen;
  import window_pkg::*;

  localparam int W = 4;
  localparam int H = 3;

  logic   clk = 1'b0;
  logic   reset;
  logic   iValid;
  logic   iSof;
  pixel_t iPixel;
  logic   oValid;
  pixel_t p00, p01, p02, p10, p11, p12, p20, p21, p22;
`ifdef WIN_COORD_EN
  logic [1:0] oCx;
  logic [1:0] oCy;
`endif

  logic [107:0] wTaps;
  logic [107:0] obsTaps [$];
  int           obsCx [$];
  int           obsCy [$];
  int           stallValidCnt;
  int           holdErrCnt;
  int           assertCount = 0;
  int           failCount = 0;

  always #5 clk = ~clk;

  window_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_valid      (iValid),
    .i_sof        (iSof),
    .i_pixel      (iPixel),
    .o_valid      (oValid),
    .PixelData_00 (p00),
    .PixelData_01 (p01),
    .PixelData_02 (p02),
    .PixelData_10 (p10),
    .PixelData_11 (p11),
    .PixelData_12 (p12),
    .PixelData_20 (p20),
    .PixelData_21 (p21),
    .PixelData_22 (p22)
`ifdef WIN_COORD_EN
    ,
    .o_cx         (oCx),
    .o_cy         (oCy)
`endif
  );

  assign wTaps = {p00, p01, p02, p10, p11, p12, p20, p21, p22};

  function automatic pixel_t pixVal(input int tag, input int x, input int y);
    return {tag[3:0], y[3:0], x[3:0]};
  endfunction

  // Expected taps for the window whose newest pixel is (x,y), row-major from top-left.
  function automatic logic [107:0] expWin(input int tag, input int x, input int y);
    logic [107:0] v;
    v = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        v = {v[95:0], pixVal(tag, x - 2 + c, y - 2 + r)};
      end
    end
    return v;
  endfunction

  function automatic logic [107:0] getObs(input int k);
    if (obsTaps.size() > k) return obsTaps[k];
    return 'x;
  endfunction

  task automatic clearObs();
    obsTaps.delete();
    obsCx.delete();
    obsCy.delete();
    stallValidCnt = 0;
    holdErrCnt    = 0;
  endtask

  // One clock of stimulus; records every flagged window and stall-cycle misbehaviour.
  task automatic applyStimulus(input logic valid, input logic sof, input pixel_t pix);
    logic [107:0] prev;
    prev   = wTaps;
    iValid = valid;
    iSof   = sof;
    iPixel = pix;
    @(posedge clk);
    #1;
    if (oValid === 1'b1) begin
      obsTaps.push_back(wTaps);
`ifdef WIN_COORD_EN
      obsCx.push_back(int'(oCx));
      obsCy.push_back(int'(oCy));
`endif
    end
    if (!valid) begin
      if (oValid !== 1'b0) stallValidCnt++;
      if (wTaps !== prev) holdErrCnt++;
    end
    iValid = 1'b0;
    iSof   = 1'b0;
  endtask

  task automatic driveFrame(input int tag, input bit sof, input bit stalls,
                            input int firstIdx, input int count);
    for (int i = firstIdx; i < count; i++) begin
      if (stalls) begin
        repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 1'b0, 12'hFFF);
      end
      applyStimulus(1'b1, sof && (i == firstIdx), pixVal(tag, i % W, i / W));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 12'hABC);
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    assertCount++;
    if (oValid !== 1'b0 || wTaps !== '0) begin
      failCount++;
      $display("[TB] FAIL reset_state: valid=%b taps=%h, required valid=0 taps=0", oValid, wTaps);
    end
`ifdef WIN_COORD_EN
    assertCount++;
    if (oCx !== 2'd0 || oCy !== 2'd0) begin
      failCount++;
      $display("[TB] FAIL reset_coord: cx=%0d cy=%0d, required 0,0", oCx, oCy);
    end
`endif
    clearObs();
    driveFrame(6, 1'b1, 1'b0, 0, 11);
    assertCount++;
    if (oValid !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL pre_reset_valid: got %b required 1", oValid);
    end
    #2 reset = 1'b1;
    #1;
    assertCount++;
    if (oValid !== 1'b0 || wTaps !== '0) begin
      failCount++;
      $display("[TB] FAIL async_reset: valid=%b taps=%h, required valid=0 taps=0", oValid, wTaps);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    clearObs();
    driveFrame(7, 1'b0, 1'b0, 0, 12);
    idle(2);
    assertCount++;
    if (obsTaps.size() !== 2) begin
      failCount++;
      $display("[TB] FAIL post_reset_count: got %0d windows required 2", obsTaps.size());
    end
    assertCount++;
    if (getObs(0) !== expWin(7, 2, 2)) begin
      failCount++;
      $display("[TB] FAIL post_reset_win0: got %h required %h", getObs(0), expWin(7, 2, 2));
    end
  endtask

  task automatic test_frame();
    $display("[TB] test_frame");
    clearObs();
    driveFrame(0, 1'b1, 1'b0, 0, 12);
    idle(3);
    assertCount++;
    if (obsTaps.size() !== 2) begin
      failCount++;
      $display("[TB] FAIL frame_count: got %0d windows required 2", obsTaps.size());
    end
    assertCount++;
    if (getObs(0) !== 108'h000_001_002_010_011_012_020_021_022) begin
      failCount++;
      $display("[TB] FAIL frame_win0: got %h required %h", getObs(0),
               108'h000_001_002_010_011_012_020_021_022);
    end
    assertCount++;
    if (getObs(1) !== 108'h001_002_003_011_012_013_021_022_023) begin
      failCount++;
      $display("[TB] FAIL frame_win1: got %h required %h", getObs(1),
               108'h001_002_003_011_012_013_021_022_023);
    end
    assertCount++;
    if (p00 !== 12'h001 || p22 !== 12'h023) begin
      failCount++;
      $display("[TB] FAIL frame_hold: p00=%h p22=%h, required 001 023", p00, p22);
    end
    assertCount++;
    if (holdErrCnt !== 0) begin
      failCount++;
      $display("[TB] FAIL frame_idle_hold: got %0d changes required 0", holdErrCnt);
    end
`ifdef WIN_COORD_EN
    assertCount++;
    if (obsCx.size() !== 2 || obsCx[0] !== 1 || obsCy[0] !== 1 || obsCx[1] !== 2 || obsCy[1] !== 1) begin
      failCount++;
      $display("[TB] FAIL frame_coords: got %0d windows of coords, required (1,1) then (2,1)", obsCx.size());
    end
    assertCount++;
    if (oCx !== 2'd2 || oCy !== 2'd1) begin
      failCount++;
      $display("[TB] FAIL coord_hold: cx=%0d cy=%0d, required 2,1", oCx, oCy);
    end
`endif
  endtask

  task automatic test_stalls();
    $display("[TB] test_stalls");
    clearObs();
    driveFrame(3, 1'b1, 1'b1, 0, 12);
    idle(2);
    assertCount++;
    if (obsTaps.size() !== 2) begin
      failCount++;
      $display("[TB] FAIL stall_count: got %0d windows required 2", obsTaps.size());
    end
    assertCount++;
    if (getObs(0) !== expWin(3, 2, 2)) begin
      failCount++;
      $display("[TB] FAIL stall_win0: got %h required %h", getObs(0), expWin(3, 2, 2));
    end
    assertCount++;
    if (getObs(1) !== expWin(3, 3, 2)) begin
      failCount++;
      $display("[TB] FAIL stall_win1: got %h required %h", getObs(1), expWin(3, 3, 2));
    end
    assertCount++;
    if (stallValidCnt !== 0) begin
      failCount++;
      $display("[TB] FAIL stall_valid: got %0d valids on stall cycles required 0", stallValidCnt);
    end
    assertCount++;
    if (holdErrCnt !== 0) begin
      failCount++;
      $display("[TB] FAIL stall_hold: got %0d tap changes on stall cycles required 0", holdErrCnt);
    end
  endtask

  task automatic test_mid_sof();
    $display("[TB] test_mid_sof");
    clearObs();
    driveFrame(1, 1'b1, 1'b0, 0, 9);
    assertCount++;
    if (obsTaps.size() !== 0) begin
      failCount++;
      $display("[TB] FAIL midsof_early: got %0d windows required 0", obsTaps.size());
    end
    driveFrame(2, 1'b1, 1'b0, 0, 12);
    idle(1);
    assertCount++;
    if (obsTaps.size() !== 2) begin
      failCount++;
      $display("[TB] FAIL midsof_count: got %0d windows required 2", obsTaps.size());
    end
    assertCount++;
    if (getObs(0) !== expWin(2, 2, 2)) begin
      failCount++;
      $display("[TB] FAIL midsof_win0: got %h required %h", getObs(0), expWin(2, 2, 2));
    end
    assertCount++;
    if (getObs(1) !== expWin(2, 3, 2)) begin
      failCount++;
      $display("[TB] FAIL midsof_win1: got %h required %h", getObs(1), expWin(2, 3, 2));
    end
  endtask

  task automatic test_back_to_back();
    $display("[TB] test_back_to_back");
    clearObs();
    driveFrame(4, 1'b1, 1'b0, 0, 12);
    driveFrame(5, 1'b0, 1'b0, 0, 12);
    idle(1);
    assertCount++;
    if (obsTaps.size() !== 4) begin
      failCount++;
      $display("[TB] FAIL b2b_count: got %0d windows required 4", obsTaps.size());
    end
    for (int k = 0; k < 4; k++) begin
      assertCount++;
      if (getObs(k) !== expWin(4 + k / 2, 2 + k % 2, 2)) begin
        failCount++;
        $display("[TB] FAIL b2b_win%0d: got %h required %h", k, getObs(k),
                 expWin(4 + k / 2, 2 + k % 2, 2));
      end
    end
  endtask

  initial begin
    reset  = 1'b1;
    iValid = 1'b0;
    iSof   = 1'b0;
    iPixel = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_frame();
    test_stalls();
    test_mid_sof();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
